hls_fp16_to_fp32_chn_o_skid: RTL and testbench

HLS_FP16_TO_FP32_CHN_O_SKID -- requirements
Module: hls_fp16_to_fp32_chn_o_skid

---
 rtl/hls_fp16_to_fp32_pkg.sv | 13 +
 rtl/hls_fp16_to_fp32_chn_o_stall_cnt.sv | 25 ++
 rtl/hls_fp16_to_fp32_chn_o_skid.sv | 100 ++++++++++
 tb/tb_hls_fp16_to_fp32_chn_o_skid.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/hls_fp16_to_fp32_pkg.sv
// Shared types and defaults for the fp16-to-fp32 output channel skid buffer.
package hls_fp16_to_fp32_pkg;

  localparam int unsigned DW_DEF = 32;
  localparam int unsigned CW_DEF = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } skid_state_e;

endpackage

// File: rtl/hls_fp16_to_fp32_chn_o_stall_cnt.sv
// Saturating count of cycles where the output channel is valid but not accepted.
module hls_fp16_to_fp32_chn_o_stall_cnt
  import hls_fp16_to_fp32_pkg::*;
#(
  parameter int unsigned CW = CW_DEF
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          perf_clr,
  input  logic          stall,
  output logic [CW-1:0] perf_stall_cnt
);

  // Clear wins over increment; the count sticks at all-ones.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      perf_stall_cnt <= '0;
    end else if (perf_clr) begin
      perf_stall_cnt <= '0;
    end else if (stall && (perf_stall_cnt != {CW{1'b1}})) begin
      perf_stall_cnt <= perf_stall_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/hls_fp16_to_fp32_chn_o_skid.sv
// Two-entry skid FIFO between the core output wait-control stage and the downstream channel.
// Optional stall counter enabled by defining HLS_FP16_TO_FP32_CHN_O_STALL_CNT_EN.
module hls_fp16_to_fp32_chn_o_skid
  import hls_fp16_to_fp32_pkg::*;
#(
  parameter int unsigned DW = DW_DEF,
  parameter int unsigned CW = CW_DEF
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          chn_o_rsci_ld_core_sct,
  input  logic [DW-1:0] chn_o_rsci_d,
  output logic          chn_o_rsci_vd,
  output logic          chn_o_pvld,
  input  logic          chn_o_prdy,
`ifdef HLS_FP16_TO_FP32_CHN_O_STALL_CNT_EN
  input  logic          perf_clr,
  output logic [CW-1:0] perf_stall_cnt,
`endif
  output logic [DW-1:0] chn_o_pd
);

  if ((DW == 0) || (CW == 0)) begin : g_bad_param
    $error("hls_fp16_to_fp32_chn_o_skid: DW and CW must be non-zero");
  end

  skid_state_e   state_q, state_d;
  logic [DW-1:0] head_q, head_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          pvld_q, vd_q;
  logic          push, pop;

  assign push          = chn_o_rsci_ld_core_sct & vd_q;
  assign pop           = pvld_q & chn_o_prdy;
  assign chn_o_pvld    = pvld_q;
  assign chn_o_rsci_vd = vd_q;
  assign chn_o_pd      = head_q;

  // Next state and data movement; a strobe while FULL is dropped since push needs vd.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d = ONE;
          head_d  = chn_o_rsci_d;
        end
      end
      ONE: begin
        if (push && !pop) begin
          state_d = FULL;
          skid_d  = chn_o_rsci_d;
        end else if (!push && pop) begin
          state_d = EMPTY;
        end else if (push && pop) begin
          head_d  = chn_o_rsci_d;
        end
      end
      FULL: begin
        if (pop) begin
          state_d = ONE;
          head_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Flags are flopped from the next state so vd has no path from prdy.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q <= EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      pvld_q  <= 1'b0;
      vd_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      pvld_q  <= (state_d != EMPTY);
      vd_q    <= (state_d != FULL);
    end
  end

`ifdef HLS_FP16_TO_FP32_CHN_O_STALL_CNT_EN
  hls_fp16_to_fp32_chn_o_stall_cnt #(
    .CW(CW)
  ) u_stall_cnt (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rstn(nvdla_core_rstn),
    .perf_clr       (perf_clr),
    .stall          (pvld_q & ~chn_o_prdy),
    .perf_stall_cnt (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_hls_fp16_to_fp32_chn_o_skid.sv
// Scoreboard bench for the output channel skid FIFO; stall counter checks when
// HLS_FP16_TO_FP32_CHN_O_STALL_CNT_EN is defined.
module tb_hls_fp16_to_fp32_chn_o_skid;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 16;

  logic          clk = 1'b0;
  logic          rstn;
  logic          ld;
  logic [DW-1:0] din;
  logic          vd;
  logic          pvld;
  logic          prdy;
  logic [DW-1:0] pd;
`ifdef HLS_FP16_TO_FP32_CHN_O_STALL_CNT_EN
  logic          perf_clr;
  logic [CW-1:0] perf_stall_cnt;
  logic [CW-1:0] stall_m;
`endif

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_q[$];
  int            occ = 0;

  always #5 clk = ~clk;

  hls_fp16_to_fp32_chn_o_skid #(
    .DW(DW),
    .CW(CW)
  ) dut (
    .nvdla_core_clk        (clk),
    .nvdla_core_rstn       (rstn),
    .chn_o_rsci_ld_core_sct(ld),
    .chn_o_rsci_d          (din),
    .chn_o_rsci_vd         (vd),
    .chn_o_pvld            (pvld),
    .chn_o_prdy            (prdy),
`ifdef HLS_FP16_TO_FP32_CHN_O_STALL_CNT_EN
    .perf_clr              (perf_clr),
    .perf_stall_cnt        (perf_stall_cnt),
`endif
    .chn_o_pd              (pd)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: occupancy model plus expected-data queue, evaluated mid-cycle.
  always @(negedge clk) begin
    logic push_m, pop_m;
    if (!rstn) begin
      chk("rst_pvld", 32'(pvld), 32'd0);
      chk("rst_vd", 32'(vd), 32'd1);
      chk("rst_pd", pd, 32'd0);
      exp_q.delete();
      occ = 0;
`ifdef HLS_FP16_TO_FP32_CHN_O_STALL_CNT_EN
      chk("rst_stall_cnt", 32'(perf_stall_cnt), 32'd0);
      stall_m = '0;
`endif
    end else begin
      chk("pvld", 32'(pvld), (occ > 0) ? 32'd1 : 32'd0);
      chk("vd", 32'(vd), (occ < 2) ? 32'd1 : 32'd0);
`ifdef HLS_FP16_TO_FP32_CHN_O_STALL_CNT_EN
      chk("stall_cnt", 32'(perf_stall_cnt), 32'(stall_m));
      if (perf_clr) stall_m = '0;
      else if ((occ > 0) && !prdy && (stall_m != 16'hFFFF)) stall_m = stall_m + 16'd1;
`endif
      pop_m  = (occ > 0) && prdy;
      push_m = ld && (occ < 2);
      if (ld && (occ == 2)) $display("note: protocol violation, write strobe while full at %0t", $time);
      if (pop_m) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_underflow: got %h expected nothing", pd);
        end else begin
          chk("pd_order", pd, exp_q.pop_front());
        end
      end
      if (push_m) exp_q.push_back(din);
      occ = occ + (push_m ? 1 : 0) - (pop_m ? 1 : 0);
    end
  end

  initial begin
    rstn = 1'b0;
    ld   = 1'b0;
    din  = '0;
    prdy = 1'b0;
`ifdef HLS_FP16_TO_FP32_CHN_O_STALL_CNT_EN
    perf_clr = 1'b0;
    stall_m  = '0;
`endif
    step(3);
    rstn = 1'b1;

    // Idle after reset
    for (int i = 0; i < 10; i++) begin
      step(1);
      chk("idle_pd", pd, 32'd0);
    end

    // Single push, one cycle latency
    prdy = 1'b1;
    ld   = 1'b1;
    din  = 32'h3F80_0000;
    step(1);
    ld = 1'b0;
    chk("single_pvld", 32'(pvld), 32'd1);
    chk("single_pd", pd, 32'h3F80_0000);
    step(1);
    chk("single_drain", 32'(pvld), 32'd0);

    // A, B fill, C dropped while full
    prdy = 1'b0;
    ld   = 1'b1;
    din  = 32'hAAAA_0001;
    step(1);
    din  = 32'hBBBB_0002;
    step(1);
    chk("full_vd", 32'(vd), 32'd0);
    din  = 32'hCCCC_0003;
    step(1);
    ld = 1'b0;
    chk("full_hold_pd", pd, 32'hAAAA_0001);
    step(2);
    prdy = 1'b1;
    step(1);
    chk("vd_after_a_pop", 32'(vd), 32'd1);
    chk("pd_b_head", pd, 32'hBBBB_0002);
    step(3);

    // Continuous streaming at one per cycle
    ld = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din = 32'h4000_0000 + 32'(i);
      step(1);
      chk("stream_pd", pd, 32'h4000_0000 + 32'(i));
    end
    ld = 1'b0;
    step(2);

    // Reset while FULL
    prdy = 1'b0;
    ld   = 1'b1;
    din  = 32'hE000_0001;
    step(1);
    din  = 32'hE000_0002;
    step(1);
    ld = 1'b0;
    chk("pre_rst_vd", 32'(vd), 32'd0);
    rstn = 1'b0;
    #1;
    chk("async_pvld", 32'(pvld), 32'd0);
    chk("async_vd", 32'(vd), 32'd1);
    chk("async_pd", pd, 32'd0);
    step(2);
    rstn = 1'b1;
    step(1);
    prdy = 1'b1;
    ld   = 1'b1;
    din  = 32'hF00D_0001;
    step(1);
    ld = 1'b0;
    chk("post_rst_pd", pd, 32'hF00D_0001);
    step(3);

`ifdef HLS_FP16_TO_FP32_CHN_O_STALL_CNT_EN
    // Saturating stall counter
    prdy = 1'b0;
    ld   = 1'b1;
    din  = 32'h1234_5678;
    step(1);
    ld       = 1'b0;
    perf_clr = 1'b1;
    step(1);
    perf_clr = 1'b0;
    step(70000);
    chk("stall_sat", 32'(perf_stall_cnt), 32'h0000_FFFF);
    perf_clr = 1'b1;
    step(1);
    perf_clr = 1'b0;
    chk("stall_clr", 32'(perf_stall_cnt), 32'd0);
    prdy = 1'b1;
    step(3);
`endif

    step(2);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
